// File: rtl/data_memory_responder.sv
// Single-outstanding MEM-stage data memory responder with a programmable wait latency.
// Optional misaligned-access rejection is enabled by defining DMEM_MISALIGN_CHECK_EN.
module data_memory_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [31:0] reqAddress,
    input  logic [1:0]  reqSize,
    input  logic        reqUnsigned,
    input  logic [31:0] reqWriteData,
    output logic        respValid,
    output logic [31:0] respReadData,
    output logic        respError,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RESPOND = 2'd2
    } state_t;

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b00:   lane_mask = 4'b0001 << lo;
            2'b01:   lane_mask = lo[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            2'b00:   lane_data = {4{wd[7:0]}};
            2'b01:   lane_data = {2{wd[15:0]}};
            default: lane_data = wd;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] lo, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lo, 3'b000} +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   load_extend = {{24{~uns & b[7]}}, b};
            2'b01:   load_extend = {{16{~uns & h[15]}}, h};
            default: load_extend = word;
        endcase
    endfunction

`ifdef DMEM_MISALIGN_CHECK_EN
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = lo[0];
            default: misaligned = (lo != 2'b00);
        endcase
    endfunction
`endif

    state_t          state_r, state_next_s;
    logic [3:0]      cnt_r, cnt_next_s;
    logic            accept_s, commit_s;

    logic            wr_r, uns_r;
    logic [AW+1:0]   addr_r;
    logic [1:0]      size_r;
    logic [31:0]     wdata_r;

    logic            eff_write_s, eff_uns_s;
    logic [AW+1:0]   eff_addr_s;
    logic [1:0]      eff_size_s;
    logic [31:0]     eff_wdata_s;

    logic [AW-1:0]   word_idx_s;
    logic [1:0]      lo_s;
    logic [31:0]     rd_word_s;
    logic [3:0]      wmask_s;
    logic [31:0]     wlanes_s;
    logic            err_s;

    logic [31:0]     mem_r [DEPTH_WORDS];

    logic            ready_r, busy_r, resp_valid_r, resp_err_r;
    logic [31:0]     resp_data_r;
    logic            unused_s;

    assign unused_s = &{1'b0, reqAddress[31:AW+2]};

    // With zero latency the commit happens on the accept edge, so use the live request fields.
    always_comb begin
        if (state_r == ST_IDLE) begin
            eff_write_s = reqWrite;
            eff_addr_s  = reqAddress[AW+1:0];
            eff_size_s  = reqSize;
            eff_uns_s   = reqUnsigned;
            eff_wdata_s = reqWriteData;
        end else begin
            eff_write_s = wr_r;
            eff_addr_s  = addr_r;
            eff_size_s  = size_r;
            eff_uns_s   = uns_r;
            eff_wdata_s = wdata_r;
        end
    end

    assign word_idx_s = eff_addr_s[AW+1:2];
    assign lo_s       = eff_addr_s[1:0];
    assign rd_word_s  = mem_r[word_idx_s];
    assign wmask_s    = lane_mask(eff_size_s, lo_s);
    assign wlanes_s   = lane_data(eff_size_s, eff_wdata_s);

`ifdef DMEM_MISALIGN_CHECK_EN
    assign err_s = misaligned(eff_size_s, lo_s);
`else
    assign err_s = 1'b0;
`endif

    // Next-state and counter logic.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        accept_s     = 1'b0;
        commit_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (reqValid) begin
                    accept_s = 1'b1;
                    if (LATENCY > 0) begin
                        state_next_s = ST_WAIT;
                        cnt_next_s   = CNT_INIT;
                    end else begin
                        state_next_s = ST_RESPOND;
                        commit_s     = 1'b1;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_next_s = ST_RESPOND;
                    commit_s     = 1'b1;
                end else begin
                    cnt_next_s = cnt_r - 4'd1;
                end
            end
            ST_RESPOND: state_next_s = ST_IDLE;
            default:    state_next_s = ST_IDLE;
        endcase
    end

    // Control, capture and response registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 4'd0;
            ready_r      <= 1'b1;
            busy_r       <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_data_r  <= 32'd0;
            wr_r         <= 1'b0;
            uns_r        <= 1'b0;
            addr_r       <= '0;
            size_r       <= 2'b00;
            wdata_r      <= 32'd0;
        end else begin
            state_r      <= state_next_s;
            cnt_r        <= cnt_next_s;
            ready_r      <= (state_next_s == ST_IDLE);
            busy_r       <= accept_s || (state_r != ST_IDLE);
            resp_valid_r <= commit_s;
            if (accept_s) begin
                wr_r    <= reqWrite;
                uns_r   <= reqUnsigned;
                addr_r  <= reqAddress[AW+1:0];
                size_r  <= reqSize;
                wdata_r <= reqWriteData;
            end
            if (commit_s) begin
                resp_err_r  <= err_s;
                resp_data_r <= (eff_write_s || err_s) ? 32'd0
                               : load_extend(rd_word_s, eff_size_s, lo_s, eff_uns_s);
            end
        end
    end

    // Storage array; contents survive reset, writes only on a live commit edge.
    always_ff @(posedge clk) begin
        if (resetN && commit_s && eff_write_s && !err_s) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask_s[i]) begin
                    mem_r[word_idx_s][8*i +: 8] <= wlanes_s[8*i +: 8];
                end
            end
        end
    end

    assign reqReady     = ready_r;
    assign busy         = busy_r;
    assign respValid    = resp_valid_r;
    assign respReadData = resp_data_r;
    assign respError    = resp_err_r;

endmodule

// File: tb/tb_data_memory_responder.sv
// Randomised self-checking bench for data_memory_responder against a byte-array memory model.
module tb_data_memory_responder;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        reqValid = 1'b0;
    logic        reqWrite = 1'b0;
    logic        reqUnsigned = 1'b0;
    logic [31:0] reqAddress = 32'h0;
    logic [31:0] reqWriteData = 32'h0;
    logic [1:0]  reqSize = 2'b00;
    logic        reqReady, respValid, respError, busy;
    logic [31:0] respReadData;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [7:0] mem_m [4*DEPTH];

    data_memory_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .resetN(resetN), .reqValid(reqValid), .reqReady(reqReady),
        .reqWrite(reqWrite), .reqAddress(reqAddress), .reqSize(reqSize),
        .reqUnsigned(reqUnsigned), .reqWriteData(reqWriteData), .respValid(respValid),
        .respReadData(respReadData), .respError(respError), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int acc_bytes(input logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic model_err(input logic [31:0] addr, input logic [1:0] size);
`ifdef DMEM_MISALIGN_CHECK_EN
        return (addr % 32'(acc_bytes(size))) != 32'd0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int base_of(input logic [31:0] addr, input logic [1:0] size);
        int a;
        a = int'(addr % 32'(4*DEPTH));
        return a - (a % acc_bytes(size));
    endfunction

    task automatic model_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wd);
        int b;
        b = base_of(addr, size);
        if (!model_err(addr, size))
            for (int i = 0; i < acc_bytes(size); i++) mem_m[b+i] = wd[8*i +: 8];
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] size, input logic uns);
        int b, n;
        longint v;
        if (model_err(addr, size)) return 32'h0;
        n = acc_bytes(size);
        b = base_of(addr, size);
        v = 0;
        for (int i = 0; i < n; i++) v = v | (longint'(mem_m[b+i]) << (8*i));
        if (!uns && n < 4 && v[8*n-1]) v = v - (longint'(1) << (8*n));
        return v[31:0];
    endfunction

    task automatic xact(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wd, output logic [31:0] rd,
                        output logic err, output int lat, output int bc, output int pl);
        int g;
        g = 0;
        while (reqReady !== 1'b1 && g < 20) begin @(negedge clk); g++; end
        reqValid = 1'b1; reqWrite = wr; reqAddress = addr; reqSize = size;
        reqUnsigned = uns; reqWriteData = wd;
        @(negedge clk);
        reqValid = 1'b0;
        rd = 32'h0; err = 1'b0; lat = -1; bc = 0; pl = 0;
        for (int k = 1; k <= LAT + 6; k++) begin
            if (busy === 1'b1) bc++;
            if (respValid === 1'b1) begin
                pl++;
                if (lat < 0) begin lat = k; rd = respReadData; err = respError; end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++; if (respValid !== 1'b0) $display("FAIL reset_respValid: got %b expected 0", respValid); else pass_cnt++;
        total_cnt++; if (respReadData !== 32'h0) $display("FAIL reset_respReadData: got %h expected 0", respReadData); else pass_cnt++;
        total_cnt++; if (respError !== 1'b0) $display("FAIL reset_respError: got %b expected 0", respError); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
        resetN = 1'b1;
        @(negedge clk);
        total_cnt++; if (reqReady !== 1'b1) $display("FAIL reset_reqReady: got %b expected 1", reqReady); else pass_cnt++;
    endtask

    task automatic test_word();
        logic [31:0] rd, e; logic err; int lat, bc, pl;
        xact(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, rd, err, lat, bc, pl);
        model_store(32'h10, 2'b10, 32'hDEADBEEF);
        total_cnt++; if (lat !== LAT + 1) $display("FAIL sw_latency: got %0d expected %0d", lat, LAT + 1); else pass_cnt++;
        total_cnt++; if (bc !== LAT + 2) $display("FAIL sw_busy_cycles: got %0d expected %0d", bc, LAT + 2); else pass_cnt++;
        total_cnt++; if (pl !== 1) $display("FAIL sw_pulses: got %0d expected 1", pl); else pass_cnt++;
        total_cnt++; if (rd !== 32'h0) $display("FAIL sw_data: got %h expected 0", rd); else pass_cnt++;
        xact(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, rd, err, lat, bc, pl);
        e = model_load(32'h10, 2'b10, 1'b0);
        total_cnt++; if (rd !== e) $display("FAIL lw_data: got %h expected %h", rd, e); else pass_cnt++;
        total_cnt++; if (lat !== LAT + 1) $display("FAIL lw_latency: got %0d expected %0d", lat, LAT + 1); else pass_cnt++;
        total_cnt++; if (bc !== LAT + 2) $display("FAIL lw_busy_cycles: got %0d expected %0d", bc, LAT + 2); else pass_cnt++;
    endtask

    task automatic test_byte();
        logic [31:0] rd, e; logic err; int lat, bc, pl;
        xact(1'b1, 32'h13, 2'b00, 1'b0, 32'h5A5A5A80, rd, err, lat, bc, pl);
        model_store(32'h13, 2'b00, 32'h5A5A5A80);
        xact(1'b0, 32'h13, 2'b00, 1'b0, 32'h0, rd, err, lat, bc, pl);
        e = model_load(32'h13, 2'b00, 1'b0);
        total_cnt++; if (rd !== e) $display("FAIL lb: got %h expected %h", rd, e); else pass_cnt++;
        xact(1'b0, 32'h13, 2'b00, 1'b1, 32'h0, rd, err, lat, bc, pl);
        e = model_load(32'h13, 2'b00, 1'b1);
        total_cnt++; if (rd !== e) $display("FAIL lbu: got %h expected %h", rd, e); else pass_cnt++;
        xact(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, rd, err, lat, bc, pl);
        e = model_load(32'h10, 2'b10, 1'b0);
        total_cnt++; if (rd !== e) $display("FAIL lw_after_sb: got %h expected %h", rd, e); else pass_cnt++;
    endtask

    task automatic test_half();
        logic [31:0] rd, e; logic err; int lat, bc, pl;
        xact(1'b1, 32'h20, 2'b10, 1'b0, 32'h0, rd, err, lat, bc, pl);
        model_store(32'h20, 2'b10, 32'h0);
        xact(1'b1, 32'h22, 2'b01, 1'b0, 32'hABCD1234, rd, err, lat, bc, pl);
        model_store(32'h22, 2'b01, 32'hABCD1234);
        xact(1'b0, 32'h22, 2'b01, 1'b0, 32'h0, rd, err, lat, bc, pl);
        e = model_load(32'h22, 2'b01, 1'b0);
        total_cnt++; if (rd !== e) $display("FAIL lh: got %h expected %h", rd, e); else pass_cnt++;
        xact(1'b0, 32'h20, 2'b10, 1'b0, 32'h0, rd, err, lat, bc, pl);
        e = model_load(32'h20, 2'b10, 1'b0);
        total_cnt++; if (rd !== e) $display("FAIL lw_after_sh: got %h expected %h", rd, e); else pass_cnt++;
        xact(1'b1, 32'h24, 2'b10, 1'b0, 32'h0, rd, err, lat, bc, pl);
        model_store(32'h24, 2'b10, 32'h0);
        xact(1'b1, 32'h24, 2'b01, 1'b0, 32'h00008001, rd, err, lat, bc, pl);
        model_store(32'h24, 2'b01, 32'h00008001);
        xact(1'b0, 32'h24, 2'b01, 1'b1, 32'h0, rd, err, lat, bc, pl);
        e = model_load(32'h24, 2'b01, 1'b1);
        total_cnt++; if (rd !== e) $display("FAIL lhu: got %h expected %h", rd, e); else pass_cnt++;
        xact(1'b0, 32'h24, 2'b01, 1'b0, 32'h0, rd, err, lat, bc, pl);
        e = model_load(32'h24, 2'b01, 1'b0);
        total_cnt++; if (rd !== e) $display("FAIL lh_neg: got %h expected %h", rd, e); else pass_cnt++;
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd, e; logic err; int lat, bc, pl, pulses;
        xact(1'b1, 32'h40, 2'b10, 1'b0, 32'h11223344, rd, err, lat, bc, pl);
        model_store(32'h40, 2'b10, 32'h11223344);
        reqValid = 1'b1; reqWrite = 1'b1; reqAddress = 32'h40; reqSize = 2'b10; reqWriteData = 32'hCAFEF00D;
        @(negedge clk);
        reqValid = 1'b0;
        resetN = 1'b0;
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            if (respValid === 1'b1) pulses++;
            @(negedge clk);
        end
        resetN = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (respValid === 1'b1) pulses++;
            @(negedge clk);
        end
        total_cnt++; if (pulses !== 0) $display("FAIL abort_pulses: got %0d expected 0", pulses); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", busy); else pass_cnt++;
        xact(1'b0, 32'h40, 2'b10, 1'b0, 32'h0, rd, err, lat, bc, pl);
        e = model_load(32'h40, 2'b10, 1'b0);
        total_cnt++; if (rd !== e) $display("FAIL abort_mem: got %h expected %h", rd, e); else pass_cnt++;
    endtask

    task automatic test_misalign();
        logic [31:0] rd, e; logic err; int lat, bc, pl;
        xact(1'b1, 32'h41, 2'b10, 1'b0, 32'hA5A5A5A5, rd, err, lat, bc, pl);
        total_cnt++; if (err !== model_err(32'h41, 2'b10)) $display("FAIL misalign_sw_err: got %b expected %b", err, model_err(32'h41, 2'b10)); else pass_cnt++;
        total_cnt++; if (lat !== LAT + 1) $display("FAIL misalign_latency: got %0d expected %0d", lat, LAT + 1); else pass_cnt++;
        model_store(32'h41, 2'b10, 32'hA5A5A5A5);
        xact(1'b0, 32'h40, 2'b10, 1'b0, 32'h0, rd, err, lat, bc, pl);
        e = model_load(32'h40, 2'b10, 1'b0);
        total_cnt++; if (rd !== e) $display("FAIL misalign_lw: got %h expected %h", rd, e); else pass_cnt++;
        total_cnt++; if (err !== 1'b0) $display("FAIL aligned_err: got %b expected 0", err); else pass_cnt++;
        xact(1'b0, 32'h40 + 32'(4*DEPTH), 2'b10, 1'b0, 32'h0, rd, err, lat, bc, pl);
        total_cnt++; if (rd !== e) $display("FAIL wrap_lw: got %h expected %h", rd, e); else pass_cnt++;
        xact(1'b0, 32'h43, 2'b01, 1'b1, 32'h0, rd, err, lat, bc, pl);
        e = model_load(32'h43, 2'b01, 1'b1);
        total_cnt++; if (rd !== e) $display("FAIL misalign_lhu: got %h expected %h", rd, e); else pass_cnt++;
        total_cnt++; if (err !== model_err(32'h43, 2'b01)) $display("FAIL misalign_lh_err: got %b expected %b", err, model_err(32'h43, 2'b01)); else pass_cnt++;
    endtask

    task automatic test_random();
        logic [31:0] rd, e, a, wd; logic err, wr, uns; logic [1:0] sz; int lat, bc, pl;
        for (int w = 0; w < 16; w++) begin
            wd = $urandom;
            xact(1'b1, 32'h100 + 32'(4*w), 2'b10, 1'b0, wd, rd, err, lat, bc, pl);
            model_store(32'h100 + 32'(4*w), 2'b10, wd);
        end
        for (int t = 0; t < 40; t++) begin
            a   = 32'h100 + 32'($urandom_range(0, 63)) + 32'($urandom_range(0, 3) * 4 * DEPTH);
            sz  = 2'($urandom_range(0, 3));
            wr  = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            wd  = $urandom;
            xact(wr, a, sz, uns, wd, rd, err, lat, bc, pl);
            e = wr ? 32'h0 : model_load(a, sz, uns);
            if (wr) model_store(a, sz, wd);
            total_cnt++; if (rd !== e) $display("FAIL rand_data[%0d] a=%h sz=%0d wr=%b: got %h expected %h", t, a, sz, wr, rd, e); else pass_cnt++;
            total_cnt++; if (err !== model_err(a, sz)) $display("FAIL rand_err[%0d]: got %b expected %b", t, err, model_err(a, sz)); else pass_cnt++;
            total_cnt++; if (lat !== LAT + 1) $display("FAIL rand_latency[%0d]: got %0d expected %0d", t, lat, LAT + 1); else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_q[$];
        logic [31:0] a, e;
        int last_acc, n_acc, n_resp;
        last_acc = -1; n_acc = 0; n_resp = 0;
        for (int i = 0; i < 38; i++) begin
            if (respValid === 1'b1) begin
                n_resp++;
                if (exp_q.size() == 0) begin
                    total_cnt++; $display("FAIL b2b_extra_pulse: got respValid at cycle %0d expected none", i);
                end else begin
                    e = exp_q.pop_front();
                    total_cnt++; if (respReadData !== e) $display("FAIL b2b_data: got %h expected %h", respReadData, e); else pass_cnt++;
                end
            end
            if (i < 30) begin
                a = 32'h100 + 32'(4 * (i % 16));
                reqValid = 1'b1; reqWrite = 1'b0; reqSize = 2'b10; reqUnsigned = 1'b0; reqAddress = a;
                if (reqReady === 1'b1) begin
                    if (last_acc >= 0) begin
                        total_cnt++; if (i - last_acc !== LAT + 2) $display("FAIL b2b_spacing: got %0d expected %0d", i - last_acc, LAT + 2); else pass_cnt++;
                    end
                    last_acc = i;
                    n_acc++;
                    exp_q.push_back(model_load(a, 2'b10, 1'b0));
                end
            end else begin
                reqValid = 1'b0;
            end
            @(negedge clk);
        end
        total_cnt++; if (n_acc !== (30 + LAT + 1) / (LAT + 2)) $display("FAIL b2b_accepts: got %0d expected %0d", n_acc, (30 + LAT + 1) / (LAT + 2)); else pass_cnt++;
        total_cnt++; if (n_resp !== n_acc) $display("FAIL b2b_responses: got %0d expected %0d", n_resp, n_acc); else pass_cnt++;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_reset_abort();
        test_misalign();
        test_random();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Responder side of the MEM-stage data-memory interface: services one load/store request at a time from the pipeline's MEM stage.
- Returns read data or a write acknowledgement after a parameterised wait latency.
- Holds `busy` high while a request is outstanding so the pipeline can stall.
- Word-organised, little-endian, byte/half/word accesses with sign/zero extension on loads.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; must be a power of two.
- LATENCY, 2, wait cycles inserted between acceptance and memory commit; legal range 0..15.

Ports:
- clk  input  1  clock, rising edge.
- resetN  input  1  asynchronous active-low reset.
- reqValid  input  1  request present.
- reqReady  output  1  responder can accept a request this cycle.
- reqWrite  input  1  1 = store, 0 = load.
- reqAddress  input  32  byte address.
- reqSize  input  2  00 byte, 01 half, 10 word; 11 is treated as word.
- reqUnsigned  input  1  load zero-extends when 1, sign-extends when 0.
- reqWriteData  input  32  store data, right-aligned (bits [7:0] for byte, [15:0] for half).
- respValid  output  1  one-cycle response pulse.
- respReadData  output  32  extended load result; 0 for stores.
- respError  output  1  request rejected (optional feature only).
- busy  output  1  high from the acceptance edge until the cycle after respValid.

Behaviour:
- **Reset (resetN low, async):**
  - state = IDLE; respValid = 0, respReadData = 0, respError = 0, busy = 0, reqReady = 1 once released.
  - Memory contents are not reset.
- **States:** IDLE, WAIT, RESPOND.
- **IDLE:**
  - reqReady = 1.
  - Request accepted on the edge where reqValid & reqReady; all req* fields are captured.
  - Next state is WAIT with counter = LATENCY-1 if LATENCY > 0, otherwise RESPOND.
- **WAIT:**
  - reqReady = 0, busy = 1.
  - Counter decrements each cycle; on the edge where it is 0, go to RESPOND.
- **Commit edge (edge entering RESPOND):**
  - A store writes only the addressed byte lanes; a load samples the word.
  - A load following a store to the same word always sees the stored data.
- **RESPOND:**
  - respValid = 1 for exactly one cycle; there is no backpressure.
  - busy = 1, reqReady = 0.
  - Next state is always IDLE.
  - respReadData and respError are held until the next response.
- **Latency:** respValid is asserted LATENCY+1 cycles after the acceptance edge.
- **Back-to-back requests:** the minimum spacing between accepted requests is LATENCY+2 cycles. reqValid while reqReady = 0 is ignored and not queued; the initiator must hold it.
- **Indexing:**
  - word index = reqAddress[log2(DEPTH_WORDS)+1:2]; upper address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS.
  - byte lane = addr[1:0]; half lane = addr[1].
- **Load extension:**
  - byte → bits 31:8 are sign or zero fill.
  - half → bits 31:16 are sign or zero fill.
  - word → unmodified.
- **Reset mid-operation:** the outstanding request is aborted and respValid is not issued. A store not yet at its commit edge does not modify memory.

Optional Feature:
- Macro: DMEM_MISALIGN_CHECK_EN.
- **Defined:**
  - A half access with addr[0] = 1, or a word access with addr[1:0] != 0, completes with normal timing, but with respError = 1, no memory write, and respReadData = 0.
  - Aligned accesses give respError = 0.
- **Undefined:**
  - respError is tied to 0.
  - Low address bits below the access size are forced to zero: half uses addr[1] only, word uses lane 0.

Test Plan:
- Store word 0xDEADBEEF @0x10, then load word @0x10 (LATENCY = 2) → respValid exactly 3 cycles after each accept; load data = 0xDEADBEEF; busy high 4 cycles per request.
- Store byte 0x80 @0x13, then lb @0x13 / lbu @0x13 / lw @0x10 → 0xFFFFFF80 / 0x00000080 / 0x80ADBEEF.
- Store half 0x1234 @0x22, then lh @0x22 and lw @0x20 on a zeroed word → 0x00001234 and 0x12340000; lhu of 0x8001 → 0x00008001.
- reqValid held continuously with a new address each cycle → only IDLE-cycle requests are accepted; accepts are spaced LATENCY+2 cycles; no extra respValid pulses.
- Store 0xCAFEF00D @0x40, pull resetN low during WAIT, release, then load @0x40 → no respValid during the aborted request; memory word unchanged from its pre-store value.
- With DMEM_MISALIGN_CHECK_EN, store word @0x41 then load word @0x40 → first response respError = 1 and memory unchanged; without the macro, the store lands at 0x40. Also load @(0x40 + 4*DEPTH_WORDS) → same data as @0x40 (wrap).
